// File: rtl/mask_unit_pkg.sv
// Shared constants, request record and scheduler state encoding for the mask-unit read path.
package mask_unit_pkg;

  localparam int unsigned N     = 4;
  localparam int unsigned VS_W  = 5;
  localparam int unsigned IDX_W = 2;
  localparam logic [2:0] STARVE_LIMIT = 3'd7;

  typedef struct packed {
    logic [VS_W-1:0]  vs;
    logic [IDX_W-1:0] offset;
    logic [IDX_W-1:0] read_lane;
    logic [IDX_W-1:0] data_offset;
  } read_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } sched_state_e;

endpackage

// File: rtl/mask_unit_starve_guard.sv
// Per-slot age counters; the oldest-starved slot suppresses lower slots sharing its read lane.
module mask_unit_starve_guard
  import mask_unit_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic [N-1:0]       pending_i,
  input  logic [N-1:0]       xbar_valid_i,
  input  logic [N-1:0]       xbar_ready_i,
  input  logic [N*IDX_W-1:0] read_lanes_i,
  output logic [N-1:0]       suppress_o
);

  logic [2:0]       age_q [N];
  logic [2:0]       age_d [N];
  logic             promo;
  logic [IDX_W-1:0] promo_idx;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      age_d[i] = age_q[i];
      if (clear_i || (xbar_valid_i[i] && xbar_ready_i[i])) begin
        age_d[i] = 3'd0;
      end else if (pending_i[i] && xbar_valid_i[i] && (age_q[i] != STARVE_LIMIT)) begin
        age_d[i] = age_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N); i++) age_q[i] <= 3'd0;
    end else begin
      for (int i = 0; i < int'(N); i++) age_q[i] <= age_d[i];
    end
  end

  // Later iterations overwrite earlier ones, so the highest starved index wins.
  always_comb begin
    promo     = 1'b0;
    promo_idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (age_q[i] == STARVE_LIMIT) begin
        promo     = 1'b1;
        promo_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    suppress_o = '0;
    for (int j = 0; j < int'(N); j++) begin
      if (promo && (j < int'(promo_idx)) &&
          (read_lanes_i[j*IDX_W +: IDX_W] == read_lanes_i[int'(promo_idx)*IDX_W +: IDX_W])) begin
        suppress_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mask_unit_read_scheduler.sv
// Issues one group of mask-unit read requests into the read crossbar and tracks responses.
module mask_unit_read_scheduler
  import mask_unit_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               group_valid_i,
  output logic               group_ready_o,
  input  logic [N-1:0]       group_mask_i,
  input  logic [N*VS_W-1:0]  group_vs_i,
  input  logic [N*IDX_W-1:0] group_offset_i,
  input  logic [N*IDX_W-1:0] group_read_lane_i,
  input  logic [N*IDX_W-1:0] group_data_offset_i,
  output logic [N-1:0]       xbar_valid_o,
  input  logic [N-1:0]       xbar_ready_i,
  output logic [N*VS_W-1:0]  xbar_vs_o,
  output logic [N*IDX_W-1:0] xbar_offset_o,
  output logic [N*IDX_W-1:0] xbar_read_lane_o,
  output logic [N*IDX_W-1:0] xbar_data_offset_o,
  input  logic [N-1:0]       resp_valid_i,
  input  logic [N*IDX_W-1:0] resp_write_index_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  sched_state_e state_q, state_d;
  read_req_t    req_q [N];
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] outstanding_q, outstanding_d;
  logic         err_q, err_d;
  logic [N-1:0] suppress, fire, clr;
  logic         accept, err_hit;

  assign accept       = (state_q == StIdle) && group_valid_i;
  assign xbar_valid_o = (state_q == StIssue) ? (pending_q & ~suppress) : '0;
  assign fire         = xbar_valid_o & xbar_ready_i;
  assign err_o        = err_q;

  mask_unit_starve_guard u_starve_guard (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .clear_i      (flush_i),
    .pending_i    (pending_q),
    .xbar_valid_i (xbar_valid_o),
    .xbar_ready_i (xbar_ready_i),
    .read_lanes_i (xbar_read_lane_o),
    .suppress_o   (suppress)
  );

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      xbar_vs_o[i*VS_W +: VS_W]           = req_q[i].vs;
      xbar_offset_o[i*IDX_W +: IDX_W]      = req_q[i].offset;
      xbar_read_lane_o[i*IDX_W +: IDX_W]   = req_q[i].read_lane;
      xbar_data_offset_o[i*IDX_W +: IDX_W] = req_q[i].data_offset;
    end
  end

  // A tag already cleared this cycle flags a duplicate across lanes.
  always_comb begin
    clr     = '0;
    err_hit = 1'b0;
    for (int l = 0; l < int'(N); l++) begin
      if (resp_valid_i[l]) begin
        if (!outstanding_q[resp_write_index_i[l*IDX_W +: IDX_W]] ||
            fire[resp_write_index_i[l*IDX_W +: IDX_W]] ||
            clr[resp_write_index_i[l*IDX_W +: IDX_W]]) begin
          err_hit = 1'b1;
        end
        clr[resp_write_index_i[l*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  always_comb begin
    pending_d     = accept ? group_mask_i : (pending_q & ~fire);
    outstanding_d = (outstanding_q & ~clr) | fire;
    err_d         = err_q | err_hit;
    if (flush_i) begin
      pending_d     = '0;
      outstanding_d = '0;
      err_d         = 1'b0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pending_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < int'(N); i++) req_q[i] <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      if (accept) begin
        for (int i = 0; i < int'(N); i++) begin
          req_q[i].vs          <= group_vs_i[i*VS_W +: VS_W];
          req_q[i].offset      <= group_offset_i[i*IDX_W +: IDX_W];
          req_q[i].read_lane   <= group_read_lane_i[i*IDX_W +: IDX_W];
          req_q[i].data_offset <= group_data_offset_i[i*IDX_W +: IDX_W];
        end
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (group_valid_i) state_d = (group_mask_i != '0) ? StIssue : StDone;
      StIssue: if (pending_d == '0) state_d = StDrain;
      StDrain: if (outstanding_d == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_comb begin
    group_ready_o = (state_q == StIdle);
    busy_o        = (state_q != StIdle);
    done_o        = (state_q == StDone);
  end

endmodule
